// File: rtl/conv_pkg.sv
// Shared constants and types for the padding front end of the 3x3 convolver.
package conv_pkg;

    localparam int IMAGE_WIDTH  = 512;
    localparam int PIXEL_DATAW  = 8;
    localparam int PADDED_WIDTH = IMAGE_WIDTH + 2;

    // Column counter spans 0..PADDED_WIDTH-1.
    localparam int COL_W = 10;

    // Column holding the last raw pixel of a row.
    localparam logic [COL_W-1:0] COL_BODY_END = COL_W'(IMAGE_WIDTH);
    // Column holding the right pad, i.e. the end of every padded row.
    localparam logic [COL_W-1:0] COL_ROW_END  = COL_W'(PADDED_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TOP    = 3'd1,
        LEFT   = 3'd2,
        BODY   = 3'd3,
        RIGHT  = 3'd4,
        BOTTOM = 3'd5
    } pad_state_t;

    typedef logic [PIXEL_DATAW-1:0] pixel_t;

    // Next column index, wrapping after the right pad.
    function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] col);
        logic [COL_W-1:0] nxt;
        if (col == COL_ROW_END) begin
            nxt = {COL_W{1'b0}};
        end else begin
            nxt = col + COL_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/conv_pad_streamer_out_reg.sv
// One-entry valid/ready output register carrying a pixel and its frame-end flag.
module pix_out_reg #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DATAW-1:0] d_y,
    input  logic             d_last,
    input  logic             i_ready,
    output logic             advance,
    output logic             o_valid,
    output logic [DATAW-1:0] o_y,
    output logic             o_last
);

    // The register may take a new word when it is empty or being drained.
    assign advance = !o_valid || i_ready;

    // Refill on advance; hold data and flag stable while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_y     <= {DATAW{1'b0}};
            o_last  <= 1'b0;
        end else if (advance) begin
            o_valid <= load;
            if (load) begin
                o_y    <= d_y;
                o_last <= d_last;
            end
        end
    end

endmodule

// File: rtl/conv_pad_streamer.sv
// Wraps a raw grayscale stream with a one-pixel zero border for the 3x3 convolver.
module conv_pad_streamer
    import conv_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic [PIXEL_DATAW-1:0] i_x,
    input  logic                   i_last,
    output logic                   o_ready,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [PIXEL_DATAW-1:0] o_y,
    output logic                   o_last
);

    pad_state_t       state_r;
    pad_state_t       state_nxt_s;
    logic [COL_W-1:0] col_r;
    logic [COL_W-1:0] col_nxt_s;
    logic             last_seen_r;
    logic             last_seen_nxt_s;
    logic             advance_s;
    logic             load_s;
    pixel_t           load_y_s;
    logic             load_last_s;
    logic             row_end_s;
    logic             body_end_s;

    assign row_end_s  = (col_r == COL_ROW_END);
    assign body_end_s = (col_r == COL_BODY_END);

    pix_out_reg #(
        .DATAW (PIXEL_DATAW)
    ) u_out (
        .clk     (clk),
        .reset   (reset),
        .load    (load_s),
        .d_y     (load_y_s),
        .d_last  (load_last_s),
        .i_ready (i_ready),
        .advance (advance_s),
        .o_valid (o_valid),
        .o_y     (o_y),
        .o_last  (o_last)
    );

    // State, column counter and frame-end flag; reset drops any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            col_r       <= {COL_W{1'b0}};
            last_seen_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            col_r       <= col_nxt_s;
            last_seen_r <= last_seen_nxt_s;
        end
    end

    // Decode next state, what the output register loads, and upstream ready.
    always_comb begin
        state_nxt_s     = state_r;
        last_seen_nxt_s = last_seen_r;
        load_s          = 1'b0;
        load_y_s        = {PIXEL_DATAW{1'b0}};
        load_last_s     = 1'b0;
        o_ready         = 1'b0;
        case (state_r)
            IDLE: begin
                // The waking pixel is left on the input; it is taken in BODY.
                if (i_valid) begin
                    state_nxt_s = TOP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TOP: begin
                load_s = advance_s;
                if (advance_s && row_end_s) begin
                    state_nxt_s = LEFT;
                end else begin
                    state_nxt_s = TOP;
                end
            end
            LEFT: begin
                load_s = advance_s;
                if (advance_s) begin
                    state_nxt_s = BODY;
                end else begin
                    state_nxt_s = LEFT;
                end
            end
            BODY: begin
                o_ready  = advance_s;
                load_s   = advance_s && i_valid;
                load_y_s = i_x;
                // Only the last raw pixel of a row may end the frame.
                if (load_s && body_end_s) begin
                    state_nxt_s     = RIGHT;
                    last_seen_nxt_s = i_last;
                end else begin
                    state_nxt_s     = BODY;
                    last_seen_nxt_s = last_seen_r;
                end
            end
            RIGHT: begin
                load_s = advance_s;
                if (advance_s) begin
                    if (last_seen_r) begin
                        state_nxt_s = BOTTOM;
                    end else begin
                        state_nxt_s = LEFT;
                    end
                end else begin
                    state_nxt_s = RIGHT;
                end
            end
            BOTTOM: begin
                load_s      = advance_s;
                load_last_s = row_end_s;
                if (advance_s && row_end_s) begin
                    state_nxt_s     = IDLE;
                    last_seen_nxt_s = 1'b0;
                end else begin
                    state_nxt_s     = BOTTOM;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                last_seen_nxt_s = 1'b0;
            end
        endcase
        if (load_s) begin
            col_nxt_s = col_next(col_r);
        end else begin
            col_nxt_s = col_r;
        end
    end

endmodule

// File: tb/tb_conv_pad_streamer.sv
// Directed, scoreboard-based bench for conv_pad_streamer.
module tb_conv_pad_streamer;
    import conv_pkg::*;

    logic   clk;
    logic   reset;
    logic   i_valid;
    pixel_t i_x;
    logic   i_last;
    logic   o_ready;
    logic   i_ready;
    logic   o_valid;
    pixel_t o_y;
    logic   o_last;

    int n_cmp      = 0;
    int n_bad      = 0;
    int rx_count   = 0;
    int last_count = 0;
    bit bp_done    = 1'b0;

    logic [PIXEL_DATAW:0] exp_q[$];

    conv_pad_streamer dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_x     (i_x),
        .i_last  (i_last),
        .o_ready (o_ready),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_y     (o_y),
        .o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raw pixel value for a given pattern, raw row and raw pixel index.
    function automatic pixel_t pix(input int mode, input int r, input int p);
        pixel_t v;
        case (mode)
            0:       v = pixel_t'(p + 1);
            1:       v = 8'hAA;
            default: v = pixel_t'(r * 37 + p * 3 + 5);
        endcase
        return v;
    endfunction

    // Expected padded output of an H-row frame.
    task automatic push_frame(input int h, input int mode);
        for (int c = 0; c < PADDED_WIDTH; c++) exp_q.push_back(9'h000);
        for (int r = 0; r < h; r++) begin
            exp_q.push_back(9'h000);
            for (int p = 0; p < IMAGE_WIDTH; p++) exp_q.push_back({1'b0, pix(mode, r, p)});
            exp_q.push_back(9'h000);
        end
        for (int c = 0; c < PADDED_WIDTH; c++)
            exp_q.push_back((c == PADDED_WIDTH - 1) ? 9'h100 : 9'h000);
    endtask

    // Offer one raw pixel and return #1 after the edge that accepts it.
    task automatic send_pixel(input pixel_t x, input logic last);
        logic acc;
        bit   ok;
        i_valid = 1'b1;
        i_x     = x;
        i_last  = last;
        ok      = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send_frame(input int h, input int mode, input int bad_row,
                              input int bad_p, input int bubble_p);
        logic lst;
        for (int r = 0; r < h; r++) begin
            for (int p = 0; p < IMAGE_WIDTH; p++) begin
                if (r == 0 && p == bubble_p) begin
                    i_valid = 1'b0;
                    repeat (3) begin
                        @(posedge clk);
                        #1;
                        check("bubble_gap", 32'(o_valid), 32'd0);
                    end
                end
                lst = ((r == h - 1) && (p == IMAGE_WIDTH - 1)) || ((r == bad_row) && (p == bad_p));
                send_pixel(pix(mode, r, p), lst);
            end
        end
    endtask

    task automatic drain_check(input string tag, input int rx_base, input int last_base,
                               input int exp_rx, input int exp_last);
        for (int c = 0; c < 6000 && exp_q.size() != 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_count"}, 32'(rx_count - rx_base), 32'(exp_rx));
        check({tag, "_last"}, 32'(last_count - last_base), 32'(exp_last));
    endtask

    // Output monitor: scoreboard pops on transfer, stall stability check.
    initial begin
        logic [PIXEL_DATAW:0] e;
        logic   prev_stall;
        pixel_t prev_y;
        logic   prev_last;
        prev_stall = 1'b0;
        prev_y     = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(o_valid), 32'd1);
                    check("stall_y", 32'(o_y), 32'(prev_y));
                    check("stall_last", 32'(o_last), 32'(prev_last));
                end
                if (o_valid && i_ready) begin
                    rx_count++;
                    if (o_last) last_count++;
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pixel", 32'({o_last, o_y}), 32'(e));
                    end
                end
                prev_stall = o_valid && !i_ready;
                prev_y     = o_y;
                prev_last  = o_last;
            end
        end
    end

    // Absolute time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int rb;
        int lb;
        reset   = 1'b1;
        i_valid = 1'b0;
        i_x     = 8'h00;
        i_last  = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_y", 32'(o_y), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single-row frame with the p+1 ramp, plus IDLE-entry latency.
        rb = rx_count; lb = last_count;
        push_frame(1, 0);
        i_valid = 1'b1;
        i_x     = pix(0, 0, 0);
        i_last  = 1'b0;
        @(posedge clk);
        #1;
        check("lat_cycle1", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2", 32'(o_valid), 32'd1);
        send_frame(1, 0, -1, -1, -1);
        i_valid = 1'b0;
        drain_check("single_row", rb, lb, 3 * PADDED_WIDTH, 1);

        // Downstream backpressure toggling every cycle over a 3-row frame.
        rb = rx_count; lb = last_count;
        push_frame(3, 1);
        bp_done = 1'b0;
        fork
            begin
                send_frame(3, 1, -1, -1, -1);
                i_valid = 1'b0;
                drain_check("backpressure", rb, lb, 5 * PADDED_WIDTH, 1);
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1;
                    i_ready = ~i_ready;
                end
                i_ready = 1'b1;
            end
        join

        // Upstream bubble of 3 cycles before the pixel at column 100.
        rb = rx_count; lb = last_count;
        push_frame(2, 2);
        send_frame(2, 2, -1, -1, 99);
        i_valid = 1'b0;
        drain_check("bubble", rb, lb, 4 * PADDED_WIDTH, 1);

        // i_last raised at column 50 of the first row must be ignored.
        rb = rx_count; lb = last_count;
        push_frame(2, 0);
        send_frame(2, 0, 0, 49, -1);
        i_valid = 1'b0;
        drain_check("misplaced_last", rb, lb, 4 * PADDED_WIDTH, 1);

        // Asynchronous reset in the middle of the first body row.
        push_frame(2, 2);
        for (int p = 0; p < 300; p++) send_pixel(pix(2, 0, p), 1'b0);
        i_valid = 1'b0;
        check("rst_mid_pre_valid", 32'(o_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        check("rst_mid_y", 32'(o_y), 32'd0);
        check("rst_mid_last", 32'(o_last), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rb = rx_count; lb = last_count;
        push_frame(1, 2);
        send_frame(1, 2, -1, -1, -1);
        i_valid = 1'b0;
        drain_check("after_reset", rb, lb, 3 * PADDED_WIDTH, 1);

        // Two 2-row frames with no gap on i_valid.
        rb = rx_count; lb = last_count;
        push_frame(2, 0);
        push_frame(2, 2);
        send_frame(2, 0, -1, -1, -1);
        send_frame(2, 2, -1, -1, -1);
        i_valid = 1'b0;
        drain_check("back_to_back", rb, lb, 2 * 4 * PADDED_WIDTH, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_pad_streamer.md
Name: conv_pad_streamer

Overview:
- Upstream neighbour of the 3x3 convolution stage.
- Accepts a raw, unpadded grayscale image stream (IMAGE_WIDTH pixels per row, any height) and emits the zero-padded stream the convolver expects.
- Padding: one zero row above and below the image, and one zero column left and right of every row, giving IMAGE_WIDTH+2 pixels per output row.
- Valid/ready on both sides, one pixel per cycle sustained.

Parameters:
- IMAGE_WIDTH, 512, raw pixels per image row.
- PIXEL_DATAW, 8, pixel bit width (unsigned).

Ports:
- clk  input  1  operating clock.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  raw input pixel valid.
- i_x  input  PIXEL_DATAW  raw input pixel.
- i_last  input  1  with i_valid, marks the last pixel of the last raw row of the frame.
- o_ready  output  1  block can accept a raw pixel this cycle.
- i_ready  input  1  downstream convolver ready.
- o_valid  output  1  padded output pixel valid.
- o_y  output  PIXEL_DATAW  padded output pixel.
- o_last  output  1  with o_valid, marks the final pixel (bottom-right pad) of the frame.

Behaviour:
- Reset (async, active-high) clears: o_valid=0, o_y=0, o_last=0, state=IDLE, col=0, last_seen=0. Reset mid-frame discards the partial frame. The first output after reset is always a new top pad row.
- Output stage is a single register.
  - advance = !o_valid || i_ready.
  - An output transfer occurs when o_valid && i_ready.
  - While o_valid && !i_ready, o_y and o_last hold stable.
- col is a 10-bit counter over 0..IMAGE_WIDTH+1. It increments on every register load and wraps to 0 after IMAGE_WIDTH+1.
- States and transitions:
  - IDLE: o_ready=0. When i_valid=1, go to TOP (the pixel is not consumed).
  - TOP: on each advance, load 0. After loading col=IMAGE_WIDTH+1, go to LEFT.
  - LEFT: on advance, load 0 (col=0), then go to BODY.
  - BODY: o_ready=advance.
    - When i_valid && o_ready, load i_x.
    - After loading col=IMAGE_WIDTH, go to RIGHT, latching last_seen=i_last.
    - Cycles with i_valid low insert no output.
  - RIGHT: on advance, load 0 (col=IMAGE_WIDTH+1).
    - Then go to BOTTOM if last_seen, else LEFT.
  - BOTTOM: on advance, load 0. The load at col=IMAGE_WIDTH+1 also sets o_last=1. Then clear last_seen and go to IDLE.
- o_ready is 0 in every state except BODY.
- i_last is honoured only on the pixel loaded at col=IMAGE_WIDTH and is ignored elsewhere. i_valid and i_x are ignored while o_ready=0.
- Latency: the first o_valid rises 2 cycles after i_valid is seen in IDLE with i_ready=1. In BODY, input-to-output latency is 1 cycle.
- Frame of H raw rows yields exactly (H+2)*(IMAGE_WIDTH+2) outputs. With i_ready held high, the only gaps are the IDLE entry and upstream bubbles.
- A simultaneous output transfer and new load in the same cycle is legal (full throughput).
- Back-to-back frames: after the BOTTOM row, the block passes through IDLE. The next frame's first i_valid starts a new TOP row.

Decomposition:
- Package conv_pkg holds:
  - IMAGE_WIDTH, PIXEL_DATAW, and PADDED_WIDTH=IMAGE_WIDTH+2 constants;
  - a pad_state_t enum {IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM};
  - a pixel_t typedef.
- One natural sub-module: pix_out_reg, a one-entry valid/ready output register carrying {o_y, o_last}. It exposes advance and holds data under stall.
- FSM and column counter live in the top module.

Test Plan:
- Single-row frame (H=1, i_x=col+1 with i_last on col 512, i_ready=1):
  - 1542 outputs.
  - Row 0 is all 0.
  - Row 1 is 0,1..255,0..,0, with 8-bit wrap of the col+1 pattern.
  - Row 2 is all 0.
  - o_last only on output 1542.
- Backpressure: i_ready toggles 1/0 every cycle over a 3-row frame of constant 0xAA.
  - o_y and o_valid hold whenever i_ready=0.
  - Output count is 5*514.
  - Body pixels are 0xAA, pads are 0.
- Input bubbles: i_valid low for 3 cycles mid-row at col 100.
  - o_valid drops for 3 cycles.
  - No zero is inserted.
  - Pixel order is preserved.
- Misplaced i_last: assert it at col 50 of row 1 of a 2-row frame.
  - It is ignored, and the second row is accepted.
  - Bottom pad follows only the i_last at col 512 of row 2.
- Async reset mid-BODY at row 1, col 300:
  - o_valid, o_y and o_last go 0 immediately, with no clock edge needed.
  - After release, the next i_valid produces 514 zeros (top row) before body data.
- Back-to-back frames (two H=2 frames, no gap on i_valid):
  - 2*4*514 outputs, with o_last exactly twice.
  - The second frame begins with a full zero top row.
